// File: rtl/ram_io_responder_pkg.sv
// Shared address map and widths for the RAM/IO responder.
// Decode helper for the IO region lives here too.
package ram_io_responder_pkg;

  localparam int RAM_size          = 8;
  localparam int Data_Address_size = 32;

  localparam logic [Data_Address_size-1:0] IO_BASE   = 32'h0003_0000;
  localparam logic [Data_Address_size-1:0] HALT_ADDR = 32'h0003_0004;

  localparam int         IO_HI     = 17;
  localparam int         IO_LO     = 16;
  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic is_io(
    input logic [Data_Address_size-1:0] a
  );
    return a[IO_HI:IO_LO] == IO_REGION;
  endfunction

endpackage

// File: rtl/ram_io_if.sv
// Initiator <-> responder bus plus IO transmit stream.
// master = initiator side, slave = responder side.
interface ram_io_if;

  logic [ram_io_responder_pkg::Data_Address_size-1:0] mem_a;
  logic [ram_io_responder_pkg::RAM_size-1:0]          mem_dout;
  logic                                               mem_wr;
  logic [ram_io_responder_pkg::RAM_size-1:0]          mem_din;
  logic                                               io_buffer_full;
  logic                                               io_tx_valid;
  logic [ram_io_responder_pkg::RAM_size-1:0]          io_tx_data;
  logic                                               io_tx_ready;
  logic                                               prog_halt;
  logic                                               io_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, io_tx_ready,
    input  mem_din, io_buffer_full, io_tx_valid,
    input  io_tx_data, prog_halt, io_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, io_tx_ready,
    output mem_din, io_buffer_full, io_tx_valid,
    output io_tx_data, prog_halt, io_overflow
  );

endinterface

// File: rtl/ram_io_responder_io_tx_fifo.sv
// Circular byte FIFO for IO transmit with a registered
// almost-full flag that leaves one slot of slack.
module io_tx_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [RAM_size-1:0] i_data,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [RAM_size-1:0] o_data,
  output logic                o_full,
  output logic                o_accept
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] FULL_TH = (PW+1)'(FIFO_DEPTH - 1);

  logic [RAM_size-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [PW:0]         r_count;
  logic                r_full;

  logic        w_pop;
  logic        w_accept;
  logic [PW:0] w_next;

  assign w_pop    = (r_count != '0) && i_ready;
  // A full FIFO still takes a push when a pop frees the slot.
  assign w_accept = i_push && ((r_count < DEPTH_C) || w_pop);

  always_comb begin
    w_next = r_count;
    unique case ({w_accept, w_pop})
      2'b10:   w_next = r_count + 1'b1;
      2'b01:   w_next = r_count - 1'b1;
      default: w_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_accept) r_wr <= r_wr + 1'b1;
      if (w_pop)    r_rd <= r_rd + 1'b1;
      r_count <= w_next;
      r_full  <= (w_next >= FULL_TH);
    end
  end

  assign o_valid  = (r_count != '0);
  assign o_data   = r_mem[r_rd];
  assign o_full   = r_full;
  assign o_accept = w_accept;

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped IO (TX FIFO, halt flag).
// RAM starts uninitialised; INIT_FILE is kept as a parameter.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int    RAM_ADDR_W = 17,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = "test.data"
) (
  input logic     clk,
  input logic     rst_n,
  ram_io_if.slave bus
);

  logic [RAM_size-1:0] r_ram [2**RAM_ADDR_W];
  logic [RAM_size-1:0] r_din;
  logic                r_halt;
  logic                r_ovf;

  logic                  w_is_io;
  logic [RAM_ADDR_W-1:0] w_idx;
  logic                  w_push;
  logic                  w_halt;
  logic                  w_accept;

  assign w_is_io = is_io(bus.mem_a);
  assign w_idx   = bus.mem_a[RAM_ADDR_W-1:0];
  assign w_push  = bus.mem_wr && (bus.mem_a == IO_BASE);
  assign w_halt  = bus.mem_wr && (bus.mem_a == HALT_ADDR);

  localparam string unused_init_file = INIT_FILE;

  always_ff @(posedge clk) begin
    if (bus.mem_wr && !w_is_io) r_ram[w_idx] <= bus.mem_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din  <= '0;
      r_halt <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_din <= w_is_io ? '0 : r_ram[w_idx];
      if (w_halt)              r_halt <= 1'b1;
      if (w_push && !w_accept) r_ovf  <= 1'b1;
    end
  end

  io_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_data   (bus.mem_dout),
    .i_ready  (bus.io_tx_ready),
    .o_valid  (bus.io_tx_valid),
    .o_data   (bus.io_tx_data),
    .o_full   (bus.io_buffer_full),
    .o_accept (w_accept)
  );

  assign bus.mem_din     = r_din;
  assign bus.prog_halt   = r_halt;
  assign bus.io_overflow = r_ovf;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM timing, FIFO
// fill/overflow/drain, halt flag and async reset behaviour.
module tb_ram_io_responder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ram_io_if bus ();

  ram_io_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mem_a       = '0;
    bus.mem_dout    = '0;
    bus.mem_wr      = 1'b0;
    bus.io_tx_ready = 1'b0;
    #12;
    chk("rst_din",   bus.mem_din, 32'h0);
    chk("rst_full",  bus.io_buffer_full, 32'h0);
    chk("rst_valid", bus.io_tx_valid, 32'h0);
    chk("rst_halt",  bus.prog_halt, 32'h0);
    chk("rst_ovf",   bus.io_overflow, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    wr(32'h10, 8'hA5);
    rd(32'h10);
    chk("ram_rd_a5", bus.mem_din, 32'hA5);

    wr(32'h20, 8'h11);
    wr(32'h20, 8'h3C);
    chk("ram_old_11", bus.mem_din, 32'h11);
    rd(32'h20);
    chk("ram_new_3c", bus.mem_din, 32'h3C);

    rd(32'h30008);
    chk("io_rd_zero",  bus.mem_din, 32'h0);
    chk("io_rd_empty", bus.io_tx_valid, 32'h0);

    for (int i = 0; i < 7; i++) begin
      wr(32'h30000, 8'(8'h40 + i));
      if (i == 5) chk("full_at6", bus.io_buffer_full, 32'h0);
    end
    chk("full_at7",  bus.io_buffer_full, 32'h1);
    chk("head_40",   bus.io_tx_data, 32'h40);
    wr(32'h30000, 8'h47);
    chk("ovf_at8",   bus.io_overflow, 32'h0);

    bus.io_tx_ready = 1'b1;
    wr(32'h30000, 8'h48);
    chk("pp_ovf",  bus.io_overflow, 32'h0);
    chk("pp_full", bus.io_buffer_full, 32'h1);
    chk("pp_head", bus.io_tx_data, 32'h41);

    bus.io_tx_ready = 1'b0;
    wr(32'h30000, 8'h49);
    chk("ovf_at9", bus.io_overflow, 32'h1);

    rd(32'h10);
    bus.io_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_vld", bus.io_tx_valid, 32'h1);
      chk("drain_dat", bus.io_tx_data, 32'(8'h41 + i));
      tick();
    end
    chk("drain_end", bus.io_tx_valid, 32'h0);
    chk("drain_nf",  bus.io_buffer_full, 32'h0);

    bus.io_tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) wr(32'h30000, 8'(8'h60 + i));
    chk("refill_full", bus.io_buffer_full, 32'h1);
    rd(32'h30008);
    chk("io_rd2_zero", bus.mem_din, 32'h0);
    chk("io_rd2_vld",  bus.io_tx_valid, 32'h1);
    chk("io_rd2_head", bus.io_tx_data, 32'h60);
    chk("io_rd2_full", bus.io_buffer_full, 32'h1);

    wr(32'h30004, 8'h00);
    chk("halt_set",  bus.prog_halt, 32'h1);
    chk("halt_nopush", bus.io_tx_data, 32'h60);

    bus.io_tx_ready = 1'b1;
    rd(32'h10);
    chk("mid_head", bus.io_tx_data, 32'h61);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.io_tx_valid, 32'h0);
    chk("arst_halt",  bus.prog_halt, 32'h0);
    chk("arst_full",  bus.io_buffer_full, 32'h0);
    chk("arst_ovf",   bus.io_overflow, 32'h0);
    chk("arst_din",   bus.mem_din, 32'h0);

    bus.io_tx_ready = 1'b0;
    bus.mem_a       = 32'h10;
    bus.mem_wr      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_a5", bus.mem_din, 32'hA5);
    rd(32'h20);
    chk("post_rst_3c", bus.mem_din, 32'h3C);
    chk("post_rst_vld", bus.io_tx_valid, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
